// File: rtl/clk_ratio_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_mon_pkg
// Brief   : Shared state encodings and defaults for the clock ratio monitor.
// Rev     : 1.0 - initial release
// ============================================================================
package clk_mon_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle    = 2'd0;
  localparam state_t c_st_acquire = 2'd1;
  localparam state_t c_st_locked  = 2'd2;
  localparam state_t c_st_fault   = 2'd3;

  localparam int c_sync_stages_def = 2;
  localparam int c_cnt_w_def       = 8;
  localparam int c_exp_half_def    = 1;
  localparam int c_tol_def         = 0;
  localparam int c_lock_count_def  = 8;
  localparam int c_timeout_def     = 16;

  localparam int c_fault_cnt_w = 8;

endpackage
`default_nettype wire

// File: rtl/clk_ratio_monitor_if.sv
`default_nettype none
// ============================================================================
// Module  : clk_ratio_monitor_if
// Brief   : Monitored-clock input, clear control and health status bundle.
// Rev     : 1.0 - initial release
// ============================================================================
interface clk_ratio_monitor_if
  import clk_mon_pkg::*;
#(
  parameter int CNT_W = c_cnt_w_def
);

  logic                     mon_clk;
  logic                     clear_fault;
  logic                     edge_pulse;
  logic [CNT_W-1:0]         half_period;
  logic                     locked;
  logic                     fault;
  logic [c_fault_cnt_w-1:0] fault_cnt;

  modport master (
    output mon_clk,
    output clear_fault,
    input  edge_pulse,
    input  half_period,
    input  locked,
    input  fault,
    input  fault_cnt
  );

  modport slave (
    input  mon_clk,
    input  clear_fault,
    output edge_pulse,
    output half_period,
    output locked,
    output fault,
    output fault_cnt
  );

endinterface
`default_nettype wire

// File: rtl/clk_ratio_monitor_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module  : sync_edge_detect
// Brief   : Synchronises an asynchronous level and flags each transition.
// Rev     : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic edge_det,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_edge_pulse;
  logic                   w_s;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign edge_det = w_s ^ r_prev;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync       <= '0;
      r_prev       <= 1'b0;
      r_edge_pulse <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev       <= w_s;
      r_edge_pulse <= edge_det;
    end
  end

  assign edge_pulse = r_edge_pulse;

endmodule
`default_nettype wire

// File: rtl/clk_ratio_monitor.sv
`default_nettype none
// ============================================================================
// Module  : clk_ratio_monitor
// Brief   : Measures a divided clock's half-period and reports lock / fault.
// Rev     : 1.0 - initial release
// ============================================================================
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = c_sync_stages_def,
  parameter int CNT_W       = c_cnt_w_def,
  parameter int EXP_HALF    = c_exp_half_def,
  parameter int TOL         = c_tol_def,
  parameter int LOCK_COUNT  = c_lock_count_def,
  parameter int TIMEOUT     = c_timeout_def
) (
  input  logic                clk_in,
  input  logic                rst,
  clk_ratio_monitor_if.slave  mon_if
);

  localparam int                    c_good_w    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]      c_cnt_max   = '1;
  localparam logic [CNT_W-1:0]      c_exp       = CNT_W'(EXP_HALF);
  localparam logic [CNT_W-1:0]      c_tol       = CNT_W'(TOL);
  localparam logic [CNT_W-1:0]      c_timeout   = CNT_W'(TIMEOUT);
  localparam logic [c_good_w-1:0]   c_lock_last = c_good_w'(LOCK_COUNT - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         r_half_period;
  logic [c_good_w-1:0]      r_good_cnt;
  logic [c_fault_cnt_w-1:0] r_fault_cnt;

  logic                     w_edge;
  logic                     w_edge_pulse;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic [CNT_W-1:0]         w_diff;
  logic                     w_good;
  logic                     w_timeout;
  logic                     w_good_inc;
  logic                     w_good_clr;
  logic                     w_fault_inc;
  logic                     w_restart;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk_in     (clk_in),
    .rst        (rst),
    .async_in   (mon_if.mon_clk),
    .edge_det   (w_edge),
    .edge_pulse (w_edge_pulse)
  );

  // The saturated increment doubles as the measured half-period on an edge.
  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
  assign w_diff    = (w_cnt_inc >= c_exp) ? (w_cnt_inc - c_exp) : (c_exp - w_cnt_inc);
  assign w_good    = (w_diff <= c_tol);
  assign w_timeout = !w_edge && (w_cnt_inc >= c_timeout);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_inc  = 1'b0;
    w_good_clr  = 1'b0;
    w_fault_inc = 1'b0;
    w_restart   = 1'b0;
    if (mon_if.clear_fault) begin
      // A clear swallows any coincident edge or timeout.
      if (r_state == c_st_fault) begin
        w_state_nxt = c_st_idle;
        w_good_clr  = 1'b1;
        w_restart   = 1'b1;
      end
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_edge) begin
            w_state_nxt = c_st_acquire;
            w_good_clr  = 1'b1;
          end else if (w_timeout) begin
            w_state_nxt = c_st_fault;
            w_fault_inc = 1'b1;
          end
        end
        c_st_acquire: begin
          if (w_edge) begin
            if (w_good) begin
              w_good_inc = 1'b1;
              if (r_good_cnt == c_lock_last) begin
                w_state_nxt = c_st_locked;
              end
            end else begin
              w_good_clr  = 1'b1;
              w_fault_inc = 1'b1;
            end
          end else if (w_timeout) begin
            w_state_nxt = c_st_fault;
            w_fault_inc = 1'b1;
          end
        end
        c_st_locked: begin
          if ((w_edge && !w_good) || w_timeout) begin
            w_state_nxt = c_st_fault;
            w_fault_inc = 1'b1;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_comb begin
    mon_if.locked = (r_state == c_st_locked);
    mon_if.fault  = (r_state == c_st_fault);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_half_period <= '0;
      r_good_cnt    <= '0;
      r_fault_cnt   <= '0;
    end else begin
      if (w_restart || w_edge) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end

      if (w_edge) begin
        r_half_period <= w_cnt_inc;
      end

      if (w_good_clr) begin
        r_good_cnt <= '0;
      end else if (w_good_inc) begin
        r_good_cnt <= r_good_cnt + 1'b1;
      end

      if (mon_if.clear_fault) begin
        r_fault_cnt <= '0;
      end else if (w_fault_inc && (r_fault_cnt != '1)) begin
        r_fault_cnt <= r_fault_cnt + 1'b1;
      end
    end
  end

  assign mon_if.edge_pulse  = w_edge_pulse;
  assign mon_if.half_period = r_half_period;
  assign mon_if.fault_cnt   = r_fault_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_ratio_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_ratio_monitor
// Brief   : Directed stimulus with a cycle-indexed reference model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_clk_ratio_monitor;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;
  localparam int EXP_HALF    = 1;
  localparam int TOL         = 0;
  localparam int LOCK_COUNT  = 8;
  localparam int TIMEOUT     = 16;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  clk_ratio_monitor_if #(.CNT_W(CNT_W)) bus ();

  clk_ratio_monitor #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W),
    .EXP_HALF    (EXP_HALF),
    .TOL         (TOL),
    .LOCK_COUNT  (LOCK_COUNT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .mon_if (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: time-indexed. m_hist[0] is mon_clk sampled at the current
  // edge; a transition becomes visible SYNC_STAGES edges after its capture.
  typedef enum {M_IDLE, M_ACQ, M_LOCK, M_FAULT} mstate_t;
  mstate_t m_st   = M_IDLE;
  bit      m_hist [0:SYNC_STAGES+1];
  int      n_cyc    = 0;
  int      last_ref = -1;
  int      m_good   = 0;
  int      m_fcnt   = 0;
  int      m_half   = 0;
  bit      m_edge   = 1'b0;

  task automatic model_reset();
    for (int i = 0; i <= SYNC_STAGES + 1; i++) m_hist[i] = 1'b0;
    m_st = M_IDLE; n_cyc = 0; last_ref = -1;
    m_good = 0; m_fcnt = 0; m_half = 0; m_edge = 1'b0;
  endtask

  task automatic fault_bump();
    if (m_fcnt < 255) m_fcnt++;
  endtask

  task automatic model_step(input bit mon, input bit clr);
    bit ev, good_e, tmo;
    int meas, dev;
    for (int i = SYNC_STAGES + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = mon;
    ev   = (m_hist[SYNC_STAGES] != m_hist[SYNC_STAGES+1]);
    meas = n_cyc - last_ref;
    if (meas > 255) meas = 255;
    dev    = (meas > EXP_HALF) ? meas - EXP_HALF : EXP_HALF - meas;
    good_e = (dev <= TOL);
    tmo    = !ev && (meas >= TIMEOUT);
    m_edge = ev;
    if (ev) begin
      m_half   = meas;
      last_ref = n_cyc;
    end
    if (clr) begin
      m_fcnt = 0;
      if (m_st == M_FAULT) begin
        m_st = M_IDLE; m_good = 0; last_ref = n_cyc;
      end
    end else begin
      case (m_st)
        M_IDLE: begin
          if (ev) begin m_st = M_ACQ; m_good = 0; end
          else if (tmo) begin m_st = M_FAULT; fault_bump(); end
        end
        M_ACQ: begin
          if (ev) begin
            if (good_e) begin
              m_good++;
              if (m_good == LOCK_COUNT) m_st = M_LOCK;
            end else begin
              m_good = 0; fault_bump();
            end
          end else if (tmo) begin
            m_st = M_FAULT; fault_bump();
          end
        end
        M_LOCK: begin
          if ((ev && !good_e) || tmo) begin m_st = M_FAULT; fault_bump(); end
        end
        default: ;
      endcase
    end
    n_cyc++;
  endtask

  // Single compare process: advance the model, then check shortly after.
  always @(posedge clk_in or posedge rst) begin
    if (rst) model_reset();
    else     model_step(bus.mon_clk, bus.clear_fault);
    #1;
    chk("cyc_edge_pulse",  32'(bus.edge_pulse),  32'(m_edge));
    chk("cyc_half_period", 32'(bus.half_period), 32'(m_half));
    chk("cyc_locked",      32'(bus.locked),      32'(m_st == M_LOCK));
    chk("cyc_fault",       32'(bus.fault),       32'(m_st == M_FAULT));
    chk("cyc_fault_cnt",   32'(bus.fault_cnt),   32'(m_fcnt));
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.mon_clk = 1'b0;
    bus.clear_fault = 1'b0;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic tog(input int k);
    repeat (k) begin
      bus.mon_clk = ~bus.mon_clk;
      @(negedge clk_in);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mon_clk = 1'b0;
    bus.clear_fault = 1'b0;

    // 1: divide-by-2 source locks after reference edge + 8 good edges
    do_reset();
    chk("rst_locked",      32'(bus.locked),      0);
    chk("rst_fault",       32'(bus.fault),       0);
    chk("rst_edge_pulse",  32'(bus.edge_pulse),  0);
    chk("rst_half_period", 32'(bus.half_period), 0);
    chk("rst_fault_cnt",   32'(bus.fault_cnt),   0);
    tog(10);
    chk("t1_not_yet_locked", 32'(bus.locked), 0);
    tog(1);
    chk("t1_locked",      32'(bus.locked),      1);
    chk("t1_half_period", 32'(bus.half_period), 1);
    chk("t1_edge_pulse",  32'(bus.edge_pulse),  1);
    chk("t1_fault_cnt",   32'(bus.fault_cnt),   0);

    // 2: dead clock times out when cnt+1 reaches 16
    do_reset();
    repeat (15) @(negedge clk_in);
    chk("t2_pre_timeout_fault", 32'(bus.fault), 0);
    @(negedge clk_in);
    chk("t2_fault",       32'(bus.fault),       1);
    chk("t2_fault_cnt",   32'(bus.fault_cnt),   1);
    chk("t2_half_period", 32'(bus.half_period), 0);
    chk("t2_locked",      32'(bus.locked),      0);

    // 3: one 3-cycle half-period while locked, then clear and relock
    do_reset();
    tog(13);
    repeat (2) @(negedge clk_in);
    tog(2);
    chk("t3_still_locked", 32'(bus.locked), 1);
    tog(1);
    chk("t3_fault",       32'(bus.fault),       1);
    chk("t3_locked_drop", 32'(bus.locked),      0);
    chk("t3_half_period", 32'(bus.half_period), 3);
    chk("t3_fault_cnt",   32'(bus.fault_cnt),   1);
    tog(6);
    chk("t3_sticky_fault", 32'(bus.fault),       1);
    chk("t3_sticky_half",  32'(bus.half_period), 1);
    bus.clear_fault = 1'b1;
    tog(1);
    bus.clear_fault = 1'b0;
    chk("t3_clr_fault",     32'(bus.fault),     0);
    chk("t3_clr_fault_cnt", 32'(bus.fault_cnt), 0);
    tog(8);
    chk("t3_relock_early", 32'(bus.locked), 0);
    tog(1);
    chk("t3_relocked", 32'(bus.locked), 1);

    // 4: bad half-period during acquisition restarts the good count
    do_reset();
    tog(6);
    @(negedge clk_in);
    tog(10);
    chk("t4_not_locked", 32'(bus.locked),    0);
    chk("t4_no_fault",   32'(bus.fault),     0);
    chk("t4_fault_cnt",  32'(bus.fault_cnt), 1);
    tog(1);
    chk("t4_locked", 32'(bus.locked), 1);
    bus.clear_fault = 1'b1;
    tog(1);
    bus.clear_fault = 1'b0;
    chk("t4_clr_cnt_only",   32'(bus.fault_cnt), 0);
    chk("t4_clr_keeps_lock", 32'(bus.locked),    1);

    // 5: asynchronous reset between clock edges
    do_reset();
    tog(12);
    @(posedge clk_in);
    #3 rst = 1'b1;
    #1;
    chk("t5_async_locked",      32'(bus.locked),      0);
    chk("t5_async_fault",       32'(bus.fault),       0);
    chk("t5_async_edge_pulse",  32'(bus.edge_pulse),  0);
    chk("t5_async_half_period", 32'(bus.half_period), 0);
    chk("t5_async_fault_cnt",   32'(bus.fault_cnt),   0);
    do_reset();
    tog(10);
    chk("t5_restart_early", 32'(bus.locked), 0);
    tog(1);
    chk("t5_restart_locked", 32'(bus.locked), 1);

    // 6: clear coincides with a bad edge while in FAULT
    do_reset();
    repeat (20) @(negedge clk_in);
    chk("t6_fault", 32'(bus.fault), 1);
    repeat (3) begin
      bus.mon_clk = ~bus.mon_clk;
      repeat (3) @(negedge clk_in);
    end
    bus.mon_clk = ~bus.mon_clk;
    repeat (2) @(negedge clk_in);
    bus.clear_fault = 1'b1;
    @(negedge clk_in);
    bus.clear_fault = 1'b0;
    chk("t6_clr_fault",     32'(bus.fault),     0);
    chk("t6_clr_fault_cnt", 32'(bus.fault_cnt), 0);
    chk("t6_clr_locked",    32'(bus.locked),    0);
    tog(10);
    chk("t6_relock_early", 32'(bus.locked),    0);
    chk("t6_edge_unjudged", 32'(bus.fault_cnt), 0);
    tog(1);
    chk("t6_relocked", 32'(bus.locked), 1);

    repeat (2) @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
